// File: rtl/u_seqdiv16by8.sv
// u_seqdiv16by8: sequential 16-by-8 unsigned restoring divider.
// Takes one quotient bit per clock, MSB first. A nonzero divisor gives the result 16 edges
// after the accept edge. A zero divisor skips the division and goes straight to DONE with a
// saturated quotient and the dz flag set.
module u_seqdiv16by8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] q,
    output logic [7:0]  r,
    output logic        dz
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e      state_q;
    // The dividend shifts out of the top bit while quotient bits shift into the bottom bit.
    logic [15:0] dvd_q;
    logic [7:0]  div_q;
    // Partial remainder. It stays below the divisor after each step, so 8 bits hold it.
    logic [7:0]  part_q;
    logic [3:0]  cnt_q;

    logic [8:0]  trial;
    logic        trial_ge;
    logic [7:0]  part_nxt;
    logic [15:0] dvd_nxt;

    // One restoring step: shift in the next dividend bit, then subtract if the divisor fits.
    always_comb begin
        trial    = {part_q, dvd_q[15]};
        trial_ge = (trial >= {1'b0, div_q});
        part_nxt = trial_ge ? 8'(trial - {1'b0, div_q}) : trial[7:0];
        dvd_nxt  = {dvd_q[14:0], trial_ge};
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            q         <= 16'd0;
            r         <= 8'd0;
            dz        <= 1'b0;
            dvd_q     <= 16'd0;
            div_q     <= 8'd0;
            part_q    <= 8'd0;
            cnt_q     <= 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        dvd_q    <= a;
                        div_q    <= b;
                        part_q   <= 8'd0;
                        cnt_q    <= 4'd0;
                        in_ready <= 1'b0;
                        if (b == 8'd0) begin
                            q         <= 16'hFFFF;
                            r         <= a[7:0];
                            dz        <= 1'b1;
                            out_valid <= 1'b1;
                            state_q   <= StDone;
                        end else begin
                            state_q <= StBusy;
                        end
                    end
                end
                StBusy: begin
                    dvd_q  <= dvd_nxt;
                    part_q <= part_nxt;
                    cnt_q  <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        q         <= dvd_nxt;
                        r         <= part_nxt;
                        dz        <= 1'b0;
                        out_valid <= 1'b1;
                        state_q   <= StDone;
                    end
                end
                StDone: begin
                    // in_ready rises only after this edge, so no accept can share the edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_u_seqdiv16by8.sv
// Directed and randomized testbench for u_seqdiv16by8.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the same point.
module tb_u_seqdiv16by8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dz;

    int checks = 0;
    int errors = 0;

    u_seqdiv16by8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .q         (q),
        .r         (r),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Waits for in_ready (bounded), then presents one operand pair across the accept edge.
    task automatic do_accept(input logic [15:0] av, input logic [7:0] bv);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen. Stops at bound.
    task automatic wait_valid(input int bound, output int n);
        n = 0;
        while (!out_valid && n < bound) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; a = 16'h0; b = 8'h0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        checks++;
        if (q !== 16'd0 || r !== 8'd0 || dz !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: q=%0d r=%0d dz=%b, want 0 0 0", q, r, dz);
        end
    endtask

    task automatic test_basic();
        int n;
        out_ready = 1'b1;
        do_accept(16'd1000, 8'd7);
        wait_valid(40, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL basic_latency: edges=%0d, want 16", n);
        end
        checks++;
        if (q !== 16'd142 || r !== 8'd6 || dz !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: q=%0d r=%0d dz=%b, want 142 6 0", q, r, dz);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_return: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_div_zero();
        int n;
        out_ready = 1'b1;
        do_accept(16'h1234, 8'd0);
        wait_valid(40, n);
        checks++;
        if (n !== 0) begin
            errors++;
            $display("FAIL dz_latency: edges after accept=%0d, want 0", n);
        end
        checks++;
        if (q !== 16'hFFFF || r !== 8'h34 || dz !== 1'b1) begin
            errors++;
            $display("FAIL dz_result: q=%h r=%h dz=%b, want ffff 34 1", q, r, dz);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_extremes();
        logic [15:0] ta [4] = '{16'hFFFF, 16'd5, 16'hFFFF, 16'd0};
        logic [7:0]  tb [4] = '{8'hFF, 8'd9, 8'd1, 8'd5};
        logic [15:0] eq [4] = '{16'd257, 16'd0, 16'hFFFF, 16'd0};
        logic [7:0]  er [4] = '{8'd0, 8'd5, 8'd0, 8'd0};
        int n;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_accept(ta[i], tb[i]);
            wait_valid(40, n);
            checks++;
            if (n !== 16) begin
                errors++;
                $display("FAIL extreme%0d_latency: edges=%0d, want 16", i, n);
            end
            checks++;
            if (q !== eq[i] || r !== er[i] || dz !== 1'b0) begin
                errors++;
                $display("FAIL extreme%0d_result: q=%0d r=%0d dz=%b, want %0d %0d 0",
                         i, q, r, dz, eq[i], er[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int n;
        out_ready = 1'b0;
        do_accept(16'd1000, 8'd7);
        wait_valid(40, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL bp_latency: edges=%0d, want 16", n);
        end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || q !== 16'd142 || r !== 8'd6 ||
                dz !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b q=%0d r=%0d dz=%b, want 1 0 142 6 0",
                         i, out_valid, in_ready, q, r, dz);
            end
            in_valid = 1'b1;
            a = 16'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        checks++;
        if (q !== 16'd142 || r !== 8'd6) begin
            errors++;
            $display("FAIL bp_retain: q=%0d r=%0d, want 142 6", q, r);
        end
    endtask

    task automatic test_operand_change();
        int n = 0;
        out_ready = 1'b1;
        do_accept(16'd1234, 8'd13);
        while (!out_valid && n < 40) begin
            in_valid = 1'b1;
            a = 16'($urandom);
            b = 8'($urandom);
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL opchg_latency: edges=%0d, want 16", n);
        end
        checks++;
        if (q !== 16'd94 || r !== 8'd12 || dz !== 1'b0) begin
            errors++;
            $display("FAIL opchg_result: q=%0d r=%0d dz=%b, want 94 12 0", q, r, dz);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int n;
        out_ready = 1'b1;
        do_accept(16'd40000, 8'd3);
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (q !== 16'd0 || r !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state: q=%0d r=%0d out_valid=%b in_ready=%b, want 0 0 0 1",
                     q, r, out_valid, in_ready);
        end
        do_accept(16'd40000, 8'd3);
        wait_valid(40, n);
        checks++;
        if (n !== 16) begin
            errors++;
            $display("FAIL rstmid_latency: edges=%0d, want 16", n);
        end
        checks++;
        if (q !== 16'd13333 || r !== 8'd1 || dz !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_result: q=%0d r=%0d dz=%b, want 13333 1 0", q, r, dz);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [15:0] av;
        logic [7:0]  bv;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        edz;
        int          n;
        int          stall;
        for (int i = 0; i < 2000; i++) begin
            av = 16'($urandom);
            bv = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            if (bv == 8'd0) begin
                eq = 16'hFFFF; er = av[7:0]; edz = 1'b1;
            end else begin
                eq = av / {8'd0, bv}; er = 8'(av % {8'd0, bv}); edz = 1'b0;
            end
            stall = $urandom_range(0, 3);
            out_ready = 1'b0;
            do_accept(av, bv);
            wait_valid(40, n);
            repeat (stall) begin
                @(posedge clk); #1;
            end
            checks++;
            if (out_valid !== 1'b1 || q !== eq || r !== er || dz !== edz) begin
                errors++;
                $display("FAIL rand%0d a=%0d b=%0d: out_valid=%b q=%0d r=%0d dz=%b, want 1 %0d %0d %b",
                         i, av, bv, out_valid, q, r, dz, eq, er, edz);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_extremes();
        test_backpressure();
        test_operand_change();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
